train_sequencer: RTL
====================

Name: train_sequencer

Overview:
Controller that sequences the output layer through inference passes or training epochs.
- Issues sample indices to the sample/teacher memory that feeds the layer's State0/State1/Teacher streams.
- Limits how many samples are in flight and counts completion tokens (Output handshakes in inference, Delta0 handshakes in training).
- Drives the layer's iMode/iLR controls and reports when the run is done.

Parameters:
NS, 16, samples per epoch (>=2)
NE, 8, training epochs per run (>=1)
MAXOUT, 2, max outstanding samples (1..7)
LR_SWITCH, 4, epoch index from which oLR=1 (reduced learning rate)

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-high reset
iStart  in  1  start pulse, sampled only in IDLE
iTrain  in  1  run type, latched on accepted iStart: 0=inference (one pass), 1=training (NE epochs)
oMode  out  1  layer mode, held constant for the whole run
oLR  out  1  learning-rate select to layer
oValid_BM_Index  out  1  sample index valid
iReady_BM_Index  in  1  sample memory accepts index
oData_BM_Index  out  $clog2(NS)  sample index
iValid_AS_Done  in  1  completion token valid
oReady_AS_Done  out  1  completion token accept
oBusy  out  1  run in progress
oDone  out  1  one-cycle end-of-run pulse
oEpoch  out  $clog2(NE+1)  current epoch

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-run aborts immediately, with no oDone.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - iStart=1 latches iTrain into oMode and clears issued, completed and outstanding counters and oEpoch.
  - Go to ISSUE on the next cycle.
- ISSUE:
  - oValid_BM_Index = (outstanding < MAXOUT) && (issued < NS).
  - oData_BM_Index = issued (low bits).
  - A handshake (valid && ready) increments issued and outstanding.
  - oValid and oData stay stable until the handshake; oValid is never withdrawn while outstanding < MAXOUT.
  - When issued reaches NS, go to DRAIN.
- DRAIN and ISSUE both accept completions:
  - oReady_AS_Done = (outstanding > 0).
  - A handshake decrements outstanding and increments completed.
- Simultaneous index handshake and done handshake in one cycle: outstanding is unchanged; issued and completed both increment.
- A done token with outstanding = 0 is not accepted (ready low); no counter changes.
- Epoch end (completed reaches NS, outstanding = 0):
  - If oMode=0, or oEpoch+1 == NE: go to DONE.
  - Otherwise: increment oEpoch, clear issued and completed, and return to ISSUE the next cycle.
- oLR = oMode && (oEpoch >= LR_SWITCH). It is registered and updates in the same cycle as oEpoch.
- DONE: oDone=1 for exactly one cycle, then IDLE. oMode and oEpoch hold their final values until the next start.
- oBusy = 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
- iStart is ignored outside IDLE.
- Latency: first oValid_BM_Index is 1 cycle after the iStart cycle.
- Counters are $clog2(NS)+1 bits wide; no wrap-around within an epoch.

Optional Feature:
SEQ_SHUFFLE_EN
- Defined:
  - oData_BM_Index = issued XOR (oEpoch mapped into index width, bit-reversed).
  - Gives a per-epoch permuted order.
  - NS must be a power of two; elaboration error otherwise.
- Undefined: sequential order 0..NS-1 every epoch.
- Counters and handshakes are identical in both cases.

Decomposition:
- Shared package:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - index/epoch width helper constants.
- One natural sub-module: seq_credit_counter (outstanding up/down counter with the simultaneous-event rule and a full/empty flag).

Test Plan:
- Inference, NS=4, ready and done always accepted -> indices 0,1,2,3 issued; outstanding never exceeds 2; oDone 1 cycle after the 4th done; oMode=0; oEpoch=0.
- Training NE=3, NS=4, LR_SWITCH=2 -> 12 indices issued; oEpoch goes 0,1,2; oLR rises with epoch 2; single oDone.
- iReady_BM_Index held low 5 cycles -> oValid and index held stable; no counter change; issue resumes on ready.
- Done token asserted while outstanding=0 -> oReady_AS_Done=0; completed unchanged. Simultaneous issue and done with outstanding=1 -> outstanding stays 1.
- iRST asserted in epoch 1 with 2 outstanding -> next cycle all outputs 0, state IDLE, no oDone; a new iStart runs normally.
- SEQ_SHUFFLE_EN, NS=4, epoch 1 (reversed mask 2) -> indices 2,3,0,1.

Source files
------------

// File: rtl/train_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : train_sequencer_pkg
// Description : Shared types and width helpers for the train_sequencer slice.
//               Holds the run-state enum and the helpers that size the index,
//               epoch, sample-counter and credit-counter fields.
// Revision    : 1.0 - initial release
// ============================================================================
package train_sequencer_pkg;

  // Run states of the sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seqState_t;

  // Width of a sample index (NS >= 2, so never zero).
  function automatic int idxWidth(input int ns);
    return $clog2(ns);
  endfunction

  // Width of the epoch number, able to hold 0..ne.
  function automatic int epochWidth(input int ne);
    return $clog2(ne + 1);
  endfunction

  // Issued/completed counters must reach NS itself, hence one extra bit.
  function automatic int cntWidth(input int ns);
    return $clog2(ns) + 1;
  endfunction

  // Width of the outstanding-sample counter, able to hold 0..maxOut.
  function automatic int creditWidth(input int maxOut);
    return $clog2(maxOut + 1);
  endfunction

  function automatic bit isPow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/train_sequencer_credit.sv
`default_nettype none
// ============================================================================
// Module      : seq_credit_counter
// Description : Up/down counter of samples in flight. An increment and a
//               decrement in the same cycle cancel out. Reports full
//               (count >= MAX) and empty (count == 0).
// Ports       : iClk, iRst      - clock, synchronous active-high reset
//               iClr            - synchronous clear (new run)
//               iInc, iDec      - one issued sample / one completed sample
//               oFull, oEmpty   - credit limit reached / nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module seq_credit_counter #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClr,
  input  logic iInc,
  input  logic iDec,
  output logic oFull,
  output logic oEmpty
);

  localparam logic [W-1:0] c_max = W'(MAX);
  localparam logic [W-1:0] c_one = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_count <= '0;
    end else begin
      case ({iInc, iDec})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign oFull  = (r_count >= c_max);
  assign oEmpty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/train_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : train_sequencer
// Description : Sequences the output layer through one inference pass or NE
//               training epochs. Issues sample indices to the sample/teacher
//               memory, limits samples in flight to MAXOUT, counts completion
//               tokens and signals end of run with a one-cycle oDone.
// Options     : SEQ_SHUFFLE_EN - when defined, the issued index is XORed with
//               the bit-reversed epoch number (per-epoch permutation; NS must
//               be a power of two).
// Ports       : iCLK, iRST                  - clock, sync active-high reset
//               iStart, iTrain              - start pulse and run type
//               oMode, oLR                  - layer mode / learning-rate select
//               oValid/iReady/oData_BM_Index - sample index stream
//               iValid/oReady_AS_Done       - completion token stream
//               oBusy, oDone, oEpoch        - run status
// Revision    : 1.0 - initial release
// ============================================================================
module train_sequencer
  import train_sequencer_pkg::*;
#(
  parameter int NS        = 16,
  parameter int NE        = 8,
  parameter int MAXOUT    = 2,
  parameter int LR_SWITCH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iStart,
  input  logic                     iTrain,
  output logic                     oMode,
  output logic                     oLR,
  output logic                     oValid_BM_Index,
  input  logic                     iReady_BM_Index,
  output logic [$clog2(NS)-1:0]    oData_BM_Index,
  input  logic                     iValid_AS_Done,
  output logic                     oReady_AS_Done,
  output logic                     oBusy,
  output logic                     oDone,
  output logic [$clog2(NE+1)-1:0]  oEpoch
);

  localparam int c_idxW   = idxWidth(NS);
  localparam int c_epochW = epochWidth(NE);
  localparam int c_cntW   = cntWidth(NS);
  localparam int c_credW  = creditWidth(MAXOUT);

  localparam logic [c_cntW-1:0]   c_ns        = c_cntW'(NS);
  localparam logic [c_cntW-1:0]   c_nsM1      = c_cntW'(NS - 1);
  localparam logic [c_cntW-1:0]   c_cntOne    = c_cntW'(1);
  localparam logic [c_epochW-1:0] c_epochOne  = c_epochW'(1);
  localparam logic [c_epochW-1:0] c_lastEpoch = c_epochW'(NE - 1);

  seqState_t r_state;
  seqState_t w_stateNext;

  logic [c_cntW-1:0]   r_issued;
  logic [c_cntW-1:0]   r_completed;
  logic [c_epochW-1:0] r_epoch;
  logic [c_epochW-1:0] w_epochInc;
  logic                r_mode;
  logic                r_lr;

  logic w_full;
  logic w_empty;
  logic w_valid;
  logic w_ready;
  logic w_idxHs;
  logic w_doneHs;
  logic w_startAcc;
  logic w_lastIssue;
  logic w_epochEnd;
  logic w_finalEpoch;

  // --------------------------------------------------------------------------
  // Handshake qualification
  // --------------------------------------------------------------------------
  // oValid can only drop through an index handshake (issued++ / credit used),
  // because outstanding only decreases while no index is accepted.
  assign w_valid  = (r_state == ISSUE) && !w_full && (r_issued < c_ns);
  assign w_ready  = ((r_state == ISSUE) || (r_state == DRAIN)) && !w_empty;
  assign w_idxHs  = w_valid && iReady_BM_Index;
  assign w_doneHs = w_ready && iValid_AS_Done;

  assign w_startAcc  = (r_state == IDLE) && iStart;
  assign w_lastIssue = w_idxHs && (r_issued == c_nsM1);
  // The NS-th completion implies every index was issued and nothing is left
  // in flight, so the epoch ends on this handshake.
  assign w_epochEnd   = w_doneHs && (r_completed == c_nsM1);
  assign w_finalEpoch = !r_mode || (r_epoch == c_lastEpoch);
  assign w_epochInc   = r_epoch + c_epochOne;

  seq_credit_counter #(
    .MAX (MAXOUT),
    .W   (c_credW)
  ) u_credit (
    .iClk   (iCLK),
    .iRst   (iRST),
    .iClr   (w_startAcc),
    .iInc   (w_idxHs),
    .iDec   (w_doneHs),
    .oFull  (w_full),
    .oEmpty (w_empty)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    oBusy       = 1'b0;
    oDone       = 1'b0;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_stateNext = ISSUE;
        end
      end
      ISSUE: begin
        oBusy = 1'b1;
        if (w_lastIssue) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        oBusy = 1'b1;
        if (w_epochEnd) begin
          w_stateNext = w_finalEpoch ? DONE : ISSUE;
        end
      end
      DONE: begin
        oDone       = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Run counters, mode and learning-rate select
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_issued    <= '0;
      r_completed <= '0;
      r_epoch     <= '0;
      r_mode      <= 1'b0;
      r_lr        <= 1'b0;
    end else if (w_startAcc) begin
      r_issued    <= '0;
      r_completed <= '0;
      r_epoch     <= '0;
      r_mode      <= iTrain;
      r_lr        <= iTrain && (LR_SWITCH <= 0);
    end else if (w_epochEnd && !w_finalEpoch) begin
      // Next training epoch: restart index issue from zero.
      r_issued    <= '0;
      r_completed <= '0;
      r_epoch     <= w_epochInc;
      r_lr        <= r_mode && (int'(w_epochInc) >= LR_SWITCH);
    end else begin
      if (w_idxHs) begin
        r_issued <= r_issued + c_cntOne;
      end
      if (w_doneHs) begin
        r_completed <= r_completed + c_cntOne;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign oMode           = r_mode;
  assign oLR             = r_lr;
  assign oEpoch          = r_epoch;
  assign oValid_BM_Index = w_valid;
  assign oReady_AS_Done  = w_ready;

`ifdef SEQ_SHUFFLE_EN
  if (!isPow2(NS)) begin : g_nsCheck
    $error("train_sequencer: SEQ_SHUFFLE_EN requires NS to be a power of two");
  end

  logic [c_idxW-1:0] w_epochIdx;
  logic [c_idxW-1:0] w_mask;

  // Epoch truncated or zero-extended to index width, then bit-reversed so
  // that consecutive epochs flip the high-order index bits first.
  assign w_epochIdx = c_idxW'(r_epoch);

  for (genvar i = 0; i < c_idxW; i++) begin : g_rev
    assign w_mask[i] = w_epochIdx[c_idxW-1-i];
  end

  assign oData_BM_Index = r_issued[c_idxW-1:0] ^ w_mask;
`else
  assign oData_BM_Index = r_issued[c_idxW-1:0];
`endif

endmodule
`default_nettype wire
